uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter behind a small register file: TX FIFO, programmable baud
// divisor, optional parity, and a level interrupt raised when the line drains.
module uart_tx_fifo #(
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int PARITY_MODE = 0,
    parameter int DIV_RESET   = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq,
    output logic        txd
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 ovf, tx_en, irq_en;
    logic [15:0]          div;
    state_t               state, state_nx;
    logic [15:0]          div_lat, bit_cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 empty, full, busy, bit_done, pop;
    logic                 push_req, push_ok, ovf_clr;
    logic [8:0]           count_ext;
    logic [5:0]           count_sat;
    logic [DATA_BITS-1:0] head;
    logic                 unused_bits;

    assign empty     = (count == '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign busy      = (state != IDLE);
    assign head      = mem[rd_ptr];
    assign push_req  = we && (addr == 2'd0) && be[0];
    assign push_ok   = push_req && !full;
    assign ovf_clr   = we && (addr == 2'd1) && be[0] && din[9];
    assign bit_done  = (bit_cnt == div_lat - 16'd1);
    assign count_ext = 9'(count);
    assign count_sat = (count_ext > 9'd63) ? 6'd63 : count_ext[5:0];
    assign unused_bits = ^{din[31:16], be[3:2]};

    always_comb begin
        dout = '0;
        case (addr)
            2'd1:    dout = {22'b0, ovf, busy, full, empty, count_sat};
            2'd2:    dout = {30'b0, irq_en, tx_en};
            2'd3:    dout = {16'b0, div};
            default: dout = '0;
        endcase
    end

    // From STOP we pop straight into START so queued bytes leave with no gap.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (tx_en && !empty) begin
                    pop      = 1'b1;
                    state_nx = START;
                end
            end
            START:  if (bit_done) state_nx = DATA;
            DATA: begin
                if (bit_done && bit_idx == 4'(DATA_BITS - 1))
                    state_nx = (PARITY_MODE != 0) ? PARITY : STOP;
            end
            PARITY: if (bit_done) state_nx = STOP;
            STOP: begin
                if (bit_done) begin
                    if (tx_en && !empty) begin
                        pop      = 1'b1;
                        state_nx = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        txd = 1'b1;
        case (state)
            START:   txd = 1'b0;
            DATA:    txd = shreg[0];
            PARITY:  txd = par_bit;
            default: txd = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok && !rst) mem[wr_ptr] <= din[DATA_BITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            div_lat <= 16'd2;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            state <= state_nx;
            if (pop) begin
                shreg   <= head;
                par_bit <= (^head) ^ (PARITY_MODE == 2);
                div_lat <= (div < 16'd2) ? 16'd2 : div;
                bit_cnt <= '0;
                bit_idx <= '0;
            end else if (busy) begin
                if (bit_done) begin
                    bit_cnt <= '0;
                    if (state == DATA) begin
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 4'd1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            tx_en  <= 1'b0;
            irq_en <= 1'b0;
            div    <= 16'(DIV_RESET);
            irq    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_req && full) ovf <= 1'b1;
            else if (ovf_clr)     ovf <= 1'b0;
            if (we && addr == 2'd2 && be[0]) begin
                tx_en  <= din[0];
                irq_en <= din[1];
            end
            if (we && addr == 2'd3) begin
                if (be[0]) div[7:0]  <= din[7:0];
                if (be[1]) div[15:8] <= din[15:8];
            end
            irq <= irq_en & empty & ~busy;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised self-checking bench for uart_tx_fifo; expected line activity is
// built per cycle from frame rules, FIFO state from a byte queue.
module tb_uart_tx_fifo;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] din;
    logic [31:0] dout, dout_e, dout_o;
    logic        irq, irq_e, irq_o, txd, txd_e, txd_o;
    int          checks = 0;
    int          errors = 0;
    logic        exp_q[$];

    always #5 clk = ~clk;

    uart_tx_fifo dut (.clk(clk), .rst(rst), .addr(addr), .we(we), .be(be), .din(din),
                      .dout(dout), .irq(irq), .txd(txd));
    uart_tx_fifo #(.PARITY_MODE(1)) dut_e (.clk(clk), .rst(rst), .addr(addr), .we(we), .be(be),
                      .din(din), .dout(dout_e), .irq(irq_e), .txd(txd_e));
    uart_tx_fifo #(.PARITY_MODE(2)) dut_o (.clk(clk), .rst(rst), .addr(addr), .we(we), .be(be),
                      .din(din), .dout(dout_o), .irq(irq_o), .txd(txd_o));

    // Line level during bit period i of a frame (i past the end means idle).
    function automatic logic frame_bit(input logic [7:0] b, input int pm, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (pm != 0 && i == 9) return (pm == 1) ? ^b : ~^b;
        return 1'b1;
    endfunction

    task automatic add_frame(input logic [7:0] b, input int d);
        int dd;
        dd = (d < 2) ? 2 : d;
        for (int i = 0; i < 10; i++) repeat (dd) exp_q.push_back(frame_bit(b, 0, i));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
        addr = a; din = d; be = b; we = 1'b1;
        tick();
        we = 1'b0; be = 4'h0; din = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = dout;
    endtask

    task automatic do_reset();
        rst = 1'b1; we = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_stream(input string nm, input int start_k, input int empty_from);
        logic exp_e;
        addr = 2'd1;
        #1;
        for (int k = start_k; k < exp_q.size(); k++) begin
            checks++;
            if (txd !== exp_q[k]) begin
                errors++;
                $display("FAIL %s txd cycle %0d got %b exp %b", nm, k, txd, exp_q[k]);
            end
            checks++;
            if (dout[8] !== 1'b1) begin
                errors++;
                $display("FAIL %s busy cycle %0d got %b exp 1", nm, k, dout[8]);
            end
            if (empty_from >= 0 && (k == empty_from - 1 || k == empty_from)) begin
                exp_e = (k >= empty_from);
                checks++;
                if (dout[6] !== exp_e) begin
                    errors++;
                    $display("FAIL %s empty cycle %0d got %b exp %b", nm, k, dout[6], exp_e);
                end
            end
            tick();
        end
        checks++;
        if (txd !== 1'b1 || dout[8] !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after got txd=%b busy=%b exp txd=1 busy=0", nm, txd, dout[8]);
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        rd(2'd1, v);
        checks++;
        if (v !== 32'h40 || dout_e !== 32'h40 || dout_o !== 32'h40) begin
            errors++;
            $display("FAIL reset_status got %h/%h/%h exp 00000040", v, dout_e, dout_o);
        end
        rd(2'd2, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", v); end
        rd(2'd3, v);
        checks++;
        if (v !== 32'd434) begin errors++; $display("FAIL reset_div got %0d exp 434", v); end
        rd(2'd0, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reset_txdata got %h exp 0", v); end
        checks++;
        if ({txd, txd_e, txd_o} !== 3'b111 || {irq, irq_e, irq_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_lines got txd=%b%b%b irq=%b%b%b exp 111/000",
                     txd, txd_e, txd_o, irq, irq_e, irq_o);
        end
    endtask

    task automatic test_parity();
        logic [7:0] b;
        int d;
        d = 3;
        do_reset();
        wr(2'd3, 32'(d), 4'h3);
        wr(2'd2, 32'h1, 4'h1);
        for (int n = 0; n < 2; n++) begin
            b = (n == 0) ? 8'h07 : 8'($urandom);
            wr(2'd0, {24'b0, b}, 4'h1);
            tick();
            for (int c = 0; c < 11 * d; c++) begin
                checks++;
                if (txd !== frame_bit(b, 0, c / d)) begin
                    errors++;
                    $display("FAIL parity_none b=%h cycle %0d got %b exp %b", b, c, txd, frame_bit(b, 0, c / d));
                end
                checks++;
                if (txd_e !== frame_bit(b, 1, c / d)) begin
                    errors++;
                    $display("FAIL parity_even b=%h cycle %0d got %b exp %b", b, c, txd_e, frame_bit(b, 1, c / d));
                end
                checks++;
                if (txd_o !== frame_bit(b, 2, c / d)) begin
                    errors++;
                    $display("FAIL parity_odd b=%h cycle %0d got %b exp %b", b, c, txd_o, frame_bit(b, 2, c / d));
                end
                tick();
            end
        end
    endtask

    task automatic test_frame_a5();
        do_reset();
        wr(2'd3, 32'd4, 4'h3);
        wr(2'd2, 32'h1, 4'h1);
        exp_q.delete();
        add_frame(8'hA5, 4);
        wr(2'd0, 32'hA5, 4'h1);
        tick();
        run_stream("frame_a5", 0, -1);
    endtask

    task automatic test_back_to_back();
        do_reset();
        wr(2'd3, 32'd2, 4'h3);
        wr(2'd2, 32'h1, 4'h1);
        exp_q.delete();
        add_frame(8'h01, 2);
        add_frame(8'h02, 2);
        wr(2'd0, 32'h01, 4'h1);
        wr(2'd0, 32'h02, 4'h1);
        run_stream("back_to_back", 0, 20);
    endtask

    task automatic test_random_frames();
        logic [7:0] b1, b2, b3;
        int d1, d2;
        do_reset();
        for (int it = 0; it < 4; it++) begin
            d1 = (it == 0) ? 0 : int'($urandom_range(0, 6));
            d2 = (it == 0) ? 1 : int'($urandom_range(0, 6));
            b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
            wr(2'd3, 32'(d1), 4'h3);
            wr(2'd2, 32'h1, 4'h1);
            exp_q.delete();
            add_frame(b1, d1);
            add_frame(b2, d2);
            add_frame(b3, d2);
            wr(2'd0, {24'b0, b1}, 4'h1);
            wr(2'd0, {24'b0, b2}, 4'h1);
            wr(2'd0, {24'b0, b3}, 4'h1);
            wr(2'd3, 32'(d2), 4'h3);
            run_stream("random_frames", 2, -1);
        end
    endtask

    task automatic test_overflow();
        logic [7:0]  q[$];
        logic [7:0]  b;
        logic        ovf_m;
        logic [31:0] v, e;
        ovf_m = 1'b0;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            wr(2'd0, {24'b0, b}, 4'h1);
            if (q.size() < 16) q.push_back(b);
            else ovf_m = 1'b1;
            rd(2'd1, v);
            e = {22'b0, ovf_m, 1'b0, q.size() == 16, q.size() == 0, 6'(q.size())};
            checks++;
            if (v !== e) begin errors++; $display("FAIL fill_status push %0d got %h exp %h", i, v, e); end
        end
        wr(2'd1, 32'h200, 4'h0);
        rd(2'd1, v);
        checks++;
        if (v[9] !== 1'b1) begin errors++; $display("FAIL ovf_no_be got %b exp 1", v[9]); end
        wr(2'd1, 32'h200, 4'h1);
        rd(2'd1, v);
        checks++;
        if (v !== 32'h090) begin errors++; $display("FAIL ovf_clear got %h exp 00000090", v); end
        wr(2'd3, 32'd2, 4'h3);
        exp_q.delete();
        foreach (q[i]) add_frame(q[i], 2);
        wr(2'd2, 32'h1, 4'h1);
        wr(2'd0, 32'h3C, 4'h1);
        run_stream("fifo_order", 0, -1);
        rd(2'd1, v);
        checks++;
        if (v !== 32'h240) begin errors++; $display("FAIL full_pop_push got %h exp 00000240", v); end
    endtask

    task automatic test_txen_off();
        logic [7:0]  b1;
        logic [31:0] v;
        b1 = 8'($urandom);
        do_reset();
        wr(2'd3, 32'd2, 4'h3);
        wr(2'd2, 32'h1, 4'h1);
        exp_q.delete();
        add_frame(b1, 2);
        wr(2'd0, {24'b0, b1}, 4'h1);
        wr(2'd0, 32'h5A, 4'h1);
        wr(2'd2, 32'h0, 4'h1);
        run_stream("txen_off", 1, -1);
        repeat (5) tick();
        rd(2'd1, v);
        checks++;
        if (v !== 32'h001 || txd !== 1'b1) begin
            errors++;
            $display("FAIL txen_off_hold got status %h txd %b exp 00000001 1", v, txd);
        end
    endtask

    task automatic test_irq();
        logic [7:0] b;
        b = 8'($urandom);
        do_reset();
        wr(2'd3, 32'd2, 4'h3);
        wr(2'd2, 32'h3, 4'h1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_lag got %b exp 0", irq); end
        tick();
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_empty got %b exp 1", irq); end
        exp_q.delete();
        add_frame(b, 2);
        wr(2'd0, {24'b0, b}, 4'h1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_push_edge got %b exp 1", irq); end
        tick();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_push_clear got %b exp 0", irq); end
        run_stream("irq_frame", 0, -1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_busy_fall got %b exp 0", irq); end
        tick();
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got %b exp 1", irq); end
        wr(2'd0, 32'h11, 4'h1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_push2_edge got %b exp 1", irq); end
        tick();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_push2_clear got %b exp 0", irq); end
    endtask

    task automatic test_rst_mid();
        logic [7:0]  b1;
        logic [31:0] v;
        b1 = 8'($urandom);
        do_reset();
        wr(2'd3, 32'd4, 4'h3);
        wr(2'd2, 32'h1, 4'h1);
        wr(2'd0, {24'b0, b1}, 4'h1);
        wr(2'd0, 32'hC3, 4'h1);
        repeat (6) tick();
        checks++;
        if (txd !== frame_bit(b1, 0, 1)) begin
            errors++;
            $display("FAIL rst_mid_pre got %b exp %b", txd, frame_bit(b1, 0, 1));
        end
        rst = 1'b1; addr = 2'd3; din = 32'h55; be = 4'h3; we = 1'b1;
        tick();
        rst = 1'b0; we = 1'b0; be = 4'h0;
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL rst_mid_txd got %b exp 1", txd); end
        rd(2'd1, v);
        checks++;
        if (v !== 32'h040) begin errors++; $display("FAIL rst_mid_status got %h exp 00000040", v); end
        rd(2'd3, v);
        checks++;
        if (v !== 32'd434) begin errors++; $display("FAIL rst_mid_div got %0d exp 434", v); end
        rd(2'd2, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL rst_mid_ctrl got %h exp 0", v); end
        repeat (8) tick();
        rd(2'd1, v);
        checks++;
        if (txd !== 1'b1 || v !== 32'h040) begin
            errors++;
            $display("FAIL rst_mid_quiet got txd %b status %h exp 1 00000040", txd, v);
        end
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; addr = 2'd0; be = 4'h0; din = '0;
        test_reset();
        test_parity();
        test_frame_a5();
        test_back_to_back();
        test_random_frames();
        test_overflow();
        test_txen_off();
        test_irq();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got no finish exp finish before 500000");
        $fatal(1, "timeout");
    end
endmodule
